stopwatch_input_ctrl: RTL and testbench
=======================================

// Module: stopwatch_input_ctrl
// PURPOSE
//   Input side of the stopwatch: turns raw board switches and push-buttons into the
//   clean mode/control signals consumed by totalCounter and display.
//   Per input: 2-flop synchronizer. Buttons are also debounced and edge-detected.
//   Holds the pause toggle state and stretches a clear request long enough for the
//   1 Hz / 2 Hz counting domain to sample it.
// PARAMETERS
//   DEBOUNCE_CYCLES  1_000_000  consecutive clk cycles a synced button must differ from stable state to flip (10 ms @100 MHz)
//   CLR_HOLD_CYCLES  150_000_000  clk cycles clr_out stays high per clear press (1.5 s > one 1 Hz period)
//   CNT_W            28         width of debounce/hold counters; must hold max(DEBOUNCE_CYCLES, CLR_HOLD_CYCLES)
// PORTS
//   clk           in   1  100 MHz master clock
//   rst           in   1  synchronous, active-high reset
//   btn_pause     in   1  raw async pause push-button, active-high
//   btn_clear     in   1  raw async clear push-button, active-high
//   sw_adj        in   1  raw async switch: 1 = adjust mode
//   sw_sel        in   1  raw async switch: 0 = adjust minutes, 1 = adjust seconds
//   reg_mode      out  1  1 when not adjusting
//   adj_min_mode  out  1  adjusting minutes
//   adj_sec_mode  out  1  adjusting seconds
//   pause_mode    out  1  counting frozen when 1
//   clr_out       out  1  clear request to counter, held CLR_HOLD_CYCLES
// BEHAVIOUR
//   Reset (sync, rst=1 at posedge):
//     - all synchronizer, stable and counter regs <= 0.
//     - Outputs: reg_mode=1, adj_min_mode=0, adj_sec_mode=0, pause_mode=0, clr_out=0.
//   Synchronizers: sync1 <= raw; sync2 <= sync1. Applies to all four inputs.
//   Switch decode, registered one cycle after sync2:
//     - reg_mode = ~adj.
//     - adj_min_mode = adj & ~sel.
//     - adj_sec_mode = adj & sel.
//     - Exactly one of the three mode outputs is high at all times, including reset.
//   Debounce (per button):
//     - cnt clears whenever sync2 == stable.
//     - Otherwise cnt increments. When cnt == DEBOUNCE_CYCLES-1, stable <= sync2 and cnt <= 0.
//     - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
//   Press event: registered one-cycle pulse on stable 0->1. Release generates no event.
//   Latency: raw rising edge to press pulse = DEBOUNCE_CYCLES+3 clk edges.
//   Clear FSM, states IDLE / HOLD:
//     - IDLE, clear press -> HOLD: clr_out=1, hold_cnt=0.
//     - HOLD: hold_cnt++. At CLR_HOLD_CYCLES-1 -> IDLE, clr_out=0.
//     - Clear press while in HOLD restarts hold_cnt=0 (extends the pulse).
//   Pause:
//     - A pause press toggles pause_mode.
//     - Any clear press forces pause_mode=0. Clear wins over a same-cycle pause press.
//     - Pause presses while clr_out=1 are ignored.
//     - pause_mode is independent of sw_adj. Its value is kept across mode changes.
//   Holding a button does not repeat. A new event needs a debounced release, then a new press.
//   rst mid-debounce or mid-hold: all state is discarded and reset values apply next cycle.
//     - If a button is still held after rst falls, it produces a fresh press once debounced.
// TESTING (DEBOUNCE_CYCLES=4, CLR_HOLD_CYCLES=10)
//   1. Reset, then sw_adj=1, sw_sel=0
//      -> adj_min_mode=1 three cycles later.
//      Then sw_sel=1 -> adj_sec_mode=1, adj_min_mode=0 three cycles later.
//   2. btn_pause high for 20 cycles -> pause_mode 0->1 exactly 7 cycles after the press, no further toggle.
//      Release, press again -> pause_mode back to 0.
//   3. btn_pause glitch of 3 cycles -> pause_mode stays 0, no press pulse.
//   4. Clear press -> clr_out high for exactly 10 cycles.
//      A second clear press during hold -> clr_out stays high 10 cycles past the second pulse.
//   5. pause_mode=1, then press pause and clear so both pulses land in the same cycle
//      -> pause_mode=0, clr_out=1.
//   6. rst asserted mid-hold (cycle 5 of 10) -> clr_out=0 next cycle, reg_mode=1, pause_mode=0.

Source files
------------

// File: rtl/stopwatch_input_ctrl.sv
// Stopwatch input conditioning: synchronizes switches and buttons, debounces the buttons,
// decodes the adjust mode, tracks the pause toggle and stretches clear requests.
module stopwatch_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CLR_HOLD_CYCLES = 150_000_000,
    parameter int unsigned CNT_W           = 28
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_pause,
    input  logic btn_clear,
    input  logic sw_adj,
    input  logic sw_sel,
    output logic reg_mode,
    output logic adj_min_mode,
    output logic adj_sec_mode,
    output logic pause_mode,
    output logic clr_out
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CLR_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Bit order in the synchronizer: {sw_sel, sw_adj, btn_clear, btn_pause}
    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [1:0]       stable_q, stable_d;
    logic [1:0]       stable_dly_q, stable_dly_d;
    logic [CNT_W-1:0] deb_cnt_q [2];
    logic [CNT_W-1:0] deb_cnt_d [2];
    logic [1:0]       press;

    logic             reg_mode_q, reg_mode_d;
    logic             adj_min_q, adj_min_d;
    logic             adj_sec_q, adj_sec_d;
    logic             pause_q, pause_d;
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    always_comb begin
        sync1_d      = {sw_sel, sw_adj, btn_clear, btn_pause};
        sync2_d      = sync1_q;
        stable_dly_d = stable_q;
        press        = stable_q & ~stable_dly_q;

        stable_d = stable_q;
        for (int unsigned i = 0; i < 2; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CNT_ONE;
                end
            end
        end

        reg_mode_d = ~sync2_q[2];
        adj_min_d  = sync2_q[2] & ~sync2_q[3];
        adj_sec_d  = sync2_q[2] & sync2_q[3];

        // A clear press always (re)starts the hold window, even mid-hold
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        if (press[1]) begin
            state_d    = S_HOLD;
            hold_cnt_d = '0;
        end else if (state_q == S_HOLD) begin
            if (hold_cnt_q == HOLD_LAST) begin
                state_d    = S_IDLE;
                hold_cnt_d = '0;
            end else begin
                hold_cnt_d = hold_cnt_q + CNT_ONE;
            end
        end

        pause_d = pause_q;
        if (press[1]) begin
            pause_d = 1'b0;
        end else if (press[0] && (state_q != S_HOLD)) begin
            pause_d = ~pause_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            deb_cnt_q[0] <= '0;
            deb_cnt_q[1] <= '0;
            reg_mode_q   <= 1'b1;
            adj_min_q    <= 1'b0;
            adj_sec_q    <= 1'b0;
            pause_q      <= 1'b0;
            state_q      <= S_IDLE;
            hold_cnt_q   <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            deb_cnt_q    <= deb_cnt_d;
            reg_mode_q   <= reg_mode_d;
            adj_min_q    <= adj_min_d;
            adj_sec_q    <= adj_sec_d;
            pause_q      <= pause_d;
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign reg_mode     = reg_mode_q;
    assign adj_min_mode = adj_min_q;
    assign adj_sec_mode = adj_sec_q;
    assign pause_mode   = pause_q;
    assign clr_out      = (state_q == S_HOLD);

endmodule

// File: tb/tb_stopwatch_input_ctrl.sv
// Bench for stopwatch_input_ctrl: cycle model compared every cycle plus directed literal checks.
module tb_stopwatch_input_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 10;

    logic clk = 1'b0;
    logic rst, btn_pause, btn_clear, sw_adj, sw_sel;
    logic reg_mode, adj_min_mode, adj_sec_mode, pause_mode, clr_out;

    int total = 0;
    int bad   = 0;

    stopwatch_input_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .CLR_HOLD_CYCLES(HOLD),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_pause(btn_pause),
        .btn_clear(btn_clear),
        .sw_adj(sw_adj),
        .sw_sel(sw_sel),
        .reg_mode(reg_mode),
        .adj_min_mode(adj_min_mode),
        .adj_sec_mode(adj_sec_mode),
        .pause_mode(pause_mode),
        .clr_out(clr_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: raw inputs delayed two samples, a debounced level flips after DEB consecutive
    // disagreeing samples, a press acts one edge later, clear keeps a countdown of HOLD edges.
    logic [3:0] m_s1, m_s2;
    logic [1:0] m_st, m_pend;
    int         m_run [2];
    int         m_clr_left;
    logic       m_pause, m_reg, m_min, m_sec;
    bit         m_valid = 0;

    task automatic model_step();
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_st = '0; m_pend = '0;
            m_run[0] = 0; m_run[1] = 0; m_clr_left = 0;
            m_pause = 0; m_reg = 1; m_min = 0; m_sec = 0;
            m_valid = 1;
        end else begin
            m_reg = ~m_s2[2];
            m_min = m_s2[2] & ~m_s2[3];
            m_sec = m_s2[2] & m_s2[3];
            if (m_pend[1]) m_pause = 0;
            else if (m_pend[0] && m_clr_left == 0) m_pause = ~m_pause;
            if (m_pend[1]) m_clr_left = HOLD;
            else if (m_clr_left > 0) m_clr_left--;
            for (int b = 0; b < 2; b++) begin
                m_pend[b] = 0;
                if (m_s2[b] != m_st[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DEB) begin
                        m_st[b]   = m_s2[b];
                        m_run[b]  = 0;
                        m_pend[b] = m_st[b];
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = {sw_sel, sw_adj, btn_clear, btn_pause};
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("model_reg_mode", reg_mode, m_reg);
            check("model_adj_min", adj_min_mode, m_min);
            check("model_adj_sec", adj_sec_mode, m_sec);
            check("model_pause", pause_mode, m_pause);
            check("model_clr", clr_out, (m_clr_left > 0));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1; btn_pause = 0; btn_clear = 0; sw_adj = 0; sw_sel = 0;
        cyc(3);
        rst = 0;
        check("rst_reg_mode", reg_mode, 1'b1);
        check("rst_adj_min", adj_min_mode, 1'b0);
        check("rst_pause", pause_mode, 1'b0);
        check("rst_clr", clr_out, 1'b0);

        // Mode decode latency
        sw_adj = 1;
        cyc(2); check("min_early", adj_min_mode, 1'b0);
        cyc(1); check("min_on", adj_min_mode, 1'b1); check("reg_off", reg_mode, 1'b0);
        sw_sel = 1;
        cyc(2); check("sec_early", adj_sec_mode, 1'b0);
        cyc(1); check("sec_on", adj_sec_mode, 1'b1); check("min_off", adj_min_mode, 1'b0);
        sw_adj = 0;
        cyc(3); check("reg_back", reg_mode, 1'b1);

        // Held pause button toggles exactly once at press+7
        btn_pause = 1;
        cyc(6); check("pause_early", pause_mode, 1'b0);
        cyc(1); check("pause_on", pause_mode, 1'b1);
        cyc(13); check("pause_no_repeat", pause_mode, 1'b1);
        btn_pause = 0;
        cyc(10); check("pause_release", pause_mode, 1'b1);
        btn_pause = 1;
        cyc(7); check("pause_off", pause_mode, 1'b0);
        cyc(3); btn_pause = 0;
        cyc(10);

        // Three-cycle glitch is rejected
        btn_pause = 1;
        cyc(3); btn_pause = 0;
        cyc(15); check("glitch", pause_mode, 1'b0);

        // Single clear, with a pause press landing inside the hold window
        btn_clear = 1;
        cyc(3); btn_pause = 1;
        cyc(1); btn_clear = 0;
        cyc(2); check("clr_early", clr_out, 1'b0);
        cyc(1); check("clr_on", clr_out, 1'b1);
        btn_pause = 0;
        cyc(9); check("clr_last", clr_out, 1'b1);
        cyc(1); check("clr_off", clr_out, 1'b0);
        check("pause_ignored", pause_mode, 1'b0);
        cyc(10);

        // Second clear press mid-hold extends the pulse
        btn_clear = 1;
        for (int t = 1; t <= 26; t++) begin
            cyc(1);
            check("clr_extend", clr_out, (t >= 7 && t <= 24));
            btn_clear = (t < 4) || (t >= 8 && t < 12);
        end
        cyc(10);

        // Same-cycle pause and clear presses: clear wins
        btn_pause = 1;
        cyc(4); btn_pause = 0;
        cyc(8); check("pause_set", pause_mode, 1'b1);
        cyc(4);
        btn_pause = 1; btn_clear = 1;
        cyc(7); check("both_pause", pause_mode, 1'b0); check("both_clr", clr_out, 1'b1);
        btn_pause = 0; btn_clear = 0;
        cyc(20);

        // Reset mid-hold, clear button still held afterwards
        sw_adj = 1;
        cyc(5);
        btn_clear = 1;
        cyc(7); check("hold_start", clr_out, 1'b1);
        cyc(4);
        rst = 1;
        cyc(1);
        check("rst_hold_clr", clr_out, 1'b0);
        check("rst_hold_reg", reg_mode, 1'b1);
        check("rst_hold_pause", pause_mode, 1'b0);
        rst = 0;
        cyc(6); check("repress_early", clr_out, 1'b0);
        cyc(1); check("repress_on", clr_out, 1'b1);
        btn_clear = 0; sw_adj = 0;
        cyc(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
